// File: rtl/grid_io_multi.sv
// grid_io_multi: multi-channel perimeter IO tile with a double-buffered scan configuration.
//
// Each of NUM_IO pad channels has a 3-bit config: bit0 inverts the data, and bits[2:1] set the
// mode (00 disabled, 01 input, 10 output, 11 bidirectional). Configuration bits are shifted into
// a staging register over the ccff chain. A load strobe copies them into the shadow register,
// which drives the pads. The load only succeeds when exactly CHAIN_LEN bits have been shifted
// since the last load or reset.
//
// Ports:
//   prog_clk, prog_reset_n     clock and synchronous active-low reset
//   ccff_head/_shift_en/_load  scan-chain serial in, shift strobe, commit strobe
//   ccff_tail                  scan-chain serial out (registered)
//   cfg_valid, cfg_err         good commit seen since reset / last commit had the wrong length
//   gfpga_pad_GPIO_Y/_A/_OE    pad side: value from pad, value to pad, drive enable
//   pin_outpad, pin_oe         fabric side: data to pad, OE (used only in bidir mode)
//   pin_inpad                  fabric side: data from pad
module grid_io_multi #(
  parameter int unsigned NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_load,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_Y,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_A,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_OE,
  input  logic [NUM_IO-1:0] pin_outpad,
  input  logic [NUM_IO-1:0] pin_oe,
  output logic [NUM_IO-1:0] pin_inpad
);

  localparam int unsigned CFG_BITS  = 3;
  localparam int unsigned CHAIN_LEN = CFG_BITS * NUM_IO;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CHAIN_LEN);
  // One past full marks an over-length shift, so it can never match CntFull.
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  // Next-state: load has priority, and a shift in the same cycle is dropped.
  always_comb begin
    sr_d     = sr_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (ccff_load) begin
      if (count_q == CntFull) begin
        shadow_d = sr_q;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
      count_d = '0;
    end else if (ccff_shift_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      if (count_q != CntSat) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sr_q     <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = sr_q[CHAIN_LEN-1];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  // Pad datapath is purely a function of the committed shadow and the live pins.
  always_comb begin
    gfpga_pad_GPIO_OE = '0;
    gfpga_pad_GPIO_A  = '0;
    pin_inpad         = '0;
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      unique case (shadow_q[CFG_BITS*k+1 +: 2])
        2'b01: begin
          pin_inpad[k] = gfpga_pad_GPIO_Y[k] ^ shadow_q[CFG_BITS*k];
        end
        2'b10: begin
          gfpga_pad_GPIO_OE[k] = 1'b1;
          gfpga_pad_GPIO_A[k]  = pin_outpad[k] ^ shadow_q[CFG_BITS*k];
        end
        2'b11: begin
          // Input path stays live while driving, giving pad loopback.
          gfpga_pad_GPIO_OE[k] = pin_oe[k];
          gfpga_pad_GPIO_A[k]  = pin_outpad[k] ^ shadow_q[CFG_BITS*k];
          pin_inpad[k]         = gfpga_pad_GPIO_Y[k] ^ shadow_q[CFG_BITS*k];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_io_multi.sv
// Testbench for grid_io_multi (NUM_IO=4): directed scenarios with literal expectations plus a
// behavioural model of the chain/commit rules checked against the DUT every cycle.
module tb_grid_io_multi;

  localparam int NIO = 4;
  localparam int CL  = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           head, shift_en, load;
  logic           tail, valid, err;
  logic [NIO-1:0] pad_y, pad_a, pad_oe, outpad, oe_pin, inpad;

  always #5 clk = ~clk;

  grid_io_multi #(.NUM_IO(NIO)) dut (
    .prog_clk         (clk),
    .prog_reset_n     (rst_n),
    .ccff_head        (head),
    .ccff_shift_en    (shift_en),
    .ccff_load        (load),
    .ccff_tail        (tail),
    .cfg_valid        (valid),
    .cfg_err          (err),
    .gfpga_pad_GPIO_Y (pad_y),
    .gfpga_pad_GPIO_A (pad_a),
    .gfpga_pad_GPIO_OE(pad_oe),
    .pin_outpad       (outpad),
    .pin_oe           (oe_pin),
    .pin_inpad        (inpad)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the chain is a list of shifted bits; a commit captures the last CL of them.
  logic [CL-1:0] m_sr;
  logic [CL-1:0] m_shadow;
  int            m_count;
  logic          m_valid, m_err;
  bit            started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sr = '0; m_shadow = '0; m_count = 0; m_valid = 1'b0; m_err = 1'b0;
      started = 1'b1;
    end else if (load) begin
      if (m_count == CL) begin
        m_shadow = m_sr; m_valid = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_count = 0;
    end else if (shift_en) begin
      m_sr = (m_sr << 1) | CL'(head);
      if (m_count < CL + 1) m_count++;
    end
  end

  task automatic model_pads(output logic [NIO-1:0] e_oe, output logic [NIO-1:0] e_a,
                            output logic [NIO-1:0] e_in);
    int   mode;
    logic inv;
    e_oe = '0; e_a = '0; e_in = '0;
    for (int k = 0; k < NIO; k++) begin
      mode = int'((m_shadow >> (3 * k + 1)) & 12'd3);
      inv  = m_shadow[3 * k];
      if (mode == 1 || mode == 3) e_in[k] = pad_y[k] ^ inv;
      if (mode >= 2) e_a[k] = outpad[k] ^ inv;
      if (mode == 2) e_oe[k] = 1'b1;
      if (mode == 3) e_oe[k] = oe_pin[k];
    end
  endtask

  always @(negedge clk) begin
    logic [NIO-1:0] e_oe, e_a, e_in;
    if (started) begin
      model_pads(e_oe, e_a, e_in);
      chk("model_oe", 32'(pad_oe), 32'(e_oe));
      chk("model_a", 32'(pad_a), 32'(e_a));
      chk("model_inpad", 32'(inpad), 32'(e_in));
      chk("model_tail", 32'(tail), 32'(m_sr[CL-1]));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick(input logic sh, input logic hd, input logic ld);
    shift_en = sh; head = hd; load = ld;
    @(posedge clk);
    #1;
    shift_en = 1'b0; load = 1'b0; head = 1'b0;
  endtask

  // Shifts the top n bits of w MSB first, so a 12-bit word lands with w[11] at sr[11].
  task automatic shift_word(input logic [CL-1:0] w, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, w[CL-1-i], 1'b0);
  endtask

  task automatic do_load();
    tick(1'b0, 1'b0, 1'b1);
  endtask

  logic hist[$];

  initial begin
    rst_n = 1'b0; head = 1'b0; shift_en = 1'b0; load = 1'b0;
    pad_y = 4'hF; outpad = 4'hF; oe_pin = 4'h0;

    // 1. Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe", 32'(pad_oe), 32'h0);
    chk("rst_a", 32'(pad_a), 32'h0);
    chk("rst_inpad", 32'(inpad), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_tail", 32'(tail), 32'h0);
    rst_n = 1'b1;

    // 2. Good load
    pad_y = 4'b1010; outpad = 4'b0110;
    shift_word(12'b011_101_100_010, 12);
    chk("shift_oe_unchanged", 32'(pad_oe), 32'h0);
    chk("shift_valid_low", 32'(valid), 32'h0);
    do_load();
    chk("good_valid", 32'(valid), 32'h1);
    chk("good_oe", 32'(pad_oe), 32'b0110);
    chk("good_a", 32'(pad_a), 32'b0010);
    chk("good_inpad", 32'(inpad), 32'b0000);

    // 3. Short load keeps old config
    shift_word(12'hFFF, 11);
    do_load();
    chk("short_err", 32'(err), 32'h1);
    chk("short_valid", 32'(valid), 32'h1);
    chk("short_oe", 32'(pad_oe), 32'b0110);
    chk("short_a", 32'(pad_a), 32'b0010);
    shift_word(12'b011_101_100_010, 12);
    do_load();
    chk("reload_err", 32'(err), 32'h0);

    // 4. Bidir on ch0
    shift_word(12'b000_000_000_110, 12);
    do_load();
    outpad = 4'b0001; pad_y = 4'b0000; oe_pin = 4'b0000;
    #1;
    chk("bidir_oe0", 32'(pad_oe), 32'b0000);
    chk("bidir_a0", 32'(pad_a), 32'b0001);
    chk("bidir_in0", 32'(inpad), 32'b0000);
    oe_pin = 4'b0001;
    #1;
    chk("bidir_oe1", 32'(pad_oe), 32'b0001);
    pad_y = 4'b0001;
    #1;
    chk("bidir_loop_oe1", 32'(inpad), 32'b0001);
    oe_pin = 4'b0000;
    #1;
    chk("bidir_loop_oe0", 32'(inpad), 32'b0001);
    @(posedge clk); #1;

    // 5. Shift+load in one cycle commits the pre-shift chain
    pad_y = 4'b1010; outpad = 4'b0000; oe_pin = 4'b0000;
    shift_word(12'b010_010_010_010, 12);
    tick(1'b1, 1'b1, 1'b1);
    chk("sl_err", 32'(err), 32'h0);
    chk("sl_inpad", 32'(inpad), 32'b1010);
    chk("sl_oe", 32'(pad_oe), 32'b0000);
    chk("sl_tail", 32'(tail), 32'h0);
    // Count restarted at zero: exactly 12 more shifts must commit cleanly.
    shift_word(12'b100_100_100_100, 12);
    do_load();
    chk("sl_count_reset", 32'(err), 32'h0);
    chk("sl_new_oe", 32'(pad_oe), 32'b1111);

    // Chain passthrough
    for (int j = 0; j < 2 * CL; j++) begin
      logic b;
      b = ((j * 5 + 3) % 7) < 3;
      hist.push_back(b);
      tick(1'b1, b, 1'b0);
      if (j >= CL - 1) chk("passthru_tail", 32'(tail), 32'(hist[j - (CL - 1)]));
    end
    do_load();

    // 6. Reset mid-shift, then fresh load
    shift_word(12'hFC0, 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_oe", 32'(pad_oe), 32'h0);
    pad_y = 4'b1010; outpad = 4'b1110; oe_pin = 4'b0001;
    shift_word(12'b100_011_111_010, 12);
    do_load();
    chk("midrst_load_valid", 32'(valid), 32'h1);
    chk("midrst_load_err", 32'(err), 32'h0);
    chk("midrst_load_oe", 32'(pad_oe), 32'b1000);
    chk("midrst_load_a", 32'(pad_a), 32'b1000);
    chk("midrst_load_in", 32'(inpad), 32'b0100);

    // Saturation: over-length chain is rejected
    for (int i = 0; i < 20; i++) tick(1'b1, i[0], 1'b0);
    do_load();
    chk("sat_err", 32'(err), 32'h1);
    chk("sat_valid", 32'(valid), 32'h1);
    chk("sat_oe", 32'(pad_oe), 32'b1000);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
